// File: rtl/game_pkg.sv
// Shared encodings and helpers for the game sequencer slice.
// Pure declarations; no timing, no flow control.
// Not applicable: this file holds no storage.
package game_pkg;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_PLAYING   = 2'b01;
    localparam logic [1:0] ST_HIT       = 2'b10;
    localparam logic [1:0] ST_GAME_OVER = 2'b11;

    localparam int SCORE_W = 16;
    localparam int LANE_W  = 3;
    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_PLAYING   = ST_PLAYING,
        S_HIT       = ST_HIT,
        S_GAME_OVER = ST_GAME_OVER
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Frames between spawns at a given speed, never below 8.
    function automatic logic [7:0] spawn_interval(input int base, input logic [SPEED_W-1:0] spd);
        int v;
        v = base - 8 * int'(spd);
        if (v < 8) v = 8;
        return 8'(v);
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit saturating BCD score counter with a level-up lookahead flag.
// Latency: score updates the cycle after i_inc; o_level_up is combinational from state.
// No backpressure: i_inc is accepted every cycle, ignored once 9999 is reached.
module bcd_counter4
    import game_pkg::*;
#(
    parameter int LEVEL_POINTS = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_level_up
);

    localparam int LW = $clog2(LEVEL_POINTS + 1);

    logic [SCORE_W-1:0] r_score;
    logic [LW-1:0]      r_lvl;
    logic [SCORE_W-1:0] w_next;
    logic               w_sat;
    logic               w_lvl_wrap;

    always_comb begin
        logic carry;
        w_next = r_score;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    assign w_sat      = (r_score == 16'h9999);
    // r_lvl tracks score mod LEVEL_POINTS so no BCD-to-binary divide is needed.
    assign w_lvl_wrap = (r_lvl == LW'(LEVEL_POINTS - 1));
    assign o_level_up = w_lvl_wrap && !w_sat;
    assign o_score    = r_score;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score <= '0;
            r_lvl   <= '0;
        end else if (i_clr) begin
            r_score <= '0;
            r_lvl   <= '0;
        end else if (i_inc && !w_sat) begin
            r_score <= w_next;
            r_lvl   <= w_lvl_wrap ? '0 : r_lvl + LW'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Frame-level game controller: IDLE/PLAYING/HIT/GAME_OVER flow, motion ticks, spawns, score.
// Latency: all outputs registered, pulses appear the cycle after the vsync rising edge.
// No backpressure: inputs are sampled every cycle, outputs are fire-and-forget pulses/levels.
module game_sequencer
    import game_pkg::*;
#(
    parameter int          LIVES_INIT   = 3,
    parameter int          HIT_FRAMES   = 60,
    parameter int          SCORE_FRAMES = 30,
    parameter int          LEVEL_POINTS = 10,
    parameter int          SPEED_MAX    = 7,
    parameter int          SPAWN_BASE   = 64,
    parameter int          NUM_LANES    = 6,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               i_clk_100MHz,
    input  logic               i_reset,
    input  logic               i_vsync,
    input  logic               i_key_start,
    input  logic               i_collision,
    output logic               o_frame_tick,
    output logic               o_spawn,
    output logic [LANE_W-1:0]  o_spawn_lane,
    output logic [SPEED_W-1:0] o_speed,
    output logic [1:0]         o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         o_game_state
);

    localparam int FCW = $clog2(SCORE_FRAMES + 1);
    localparam int HCW = $clog2(HIT_FRAMES + 1);

    state_t             r_state, w_state_nxt;
    logic               r_vsync_q, r_key_q, r_key_armed;
    logic [15:0]        r_lfsr;
    logic [FCW-1:0]     r_frame_cnt, w_frame_cnt_nxt;
    logic [7:0]         r_spawn_cnt, w_spawn_cnt_nxt;
    logic [HCW-1:0]     r_hit_cnt, w_hit_cnt_nxt;
    logic               r_col_latch, w_col_nxt;
    logic [SPEED_W-1:0] r_speed, w_speed_nxt;
    logic [1:0]         r_lives, w_lives_nxt;
    logic               r_frame_tick, w_tick_nxt;
    logic               r_spawn, w_spawn_nxt;
    logic [LANE_W-1:0]  r_spawn_lane, w_lane_nxt;

    logic               w_fe, w_se, w_col_pend, w_level_up;
    logic               w_score_inc, w_score_clr;
    logic [LANE_W-1:0]  w_lane;
    logic [7:0]         w_interval;

    // Armed only after the key has been seen released, so a key held through reset cannot start a game.
    assign w_fe       = i_vsync & ~r_vsync_q;
    assign w_se       = i_key_start & ~r_key_q & r_key_armed;
    assign w_col_pend = r_col_latch | (i_collision & (r_state == S_PLAYING));
    assign w_lane     = LANE_W'(int'(r_lfsr[2:0]) % NUM_LANES);
    assign w_interval = spawn_interval(SPAWN_BASE, r_speed);

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_spawn_cnt_nxt = r_spawn_cnt;
        w_hit_cnt_nxt   = r_hit_cnt;
        w_col_nxt       = r_col_latch;
        w_speed_nxt     = r_speed;
        w_lives_nxt     = r_lives;
        w_tick_nxt      = 1'b0;
        w_spawn_nxt     = 1'b0;
        w_lane_nxt      = r_spawn_lane;
        w_score_inc     = 1'b0;
        w_score_clr     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_score_clr = 1'b1;
                w_speed_nxt = SPEED_W'(1);
                w_lives_nxt = 2'(LIVES_INIT);
                w_col_nxt   = 1'b0;
                if (w_se) begin
                    w_state_nxt     = S_PLAYING;
                    w_frame_cnt_nxt = '0;
                    w_spawn_cnt_nxt = w_interval;
                    w_hit_cnt_nxt   = '0;
                end
            end
            S_PLAYING, S_HIT: begin
                w_col_nxt = w_col_pend;
                if (w_fe) begin
                    w_tick_nxt = 1'b1;
                    w_col_nxt  = 1'b0;
                    if (r_frame_cnt == FCW'(SCORE_FRAMES - 1)) begin
                        w_frame_cnt_nxt = '0;
                        w_score_inc     = 1'b1;
                        if (w_level_up && (r_speed < SPEED_W'(SPEED_MAX)))
                            w_speed_nxt = r_speed + SPEED_W'(1);
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
                    end
                    if (r_spawn_cnt == 8'd0) begin
                        w_spawn_nxt     = 1'b1;
                        w_lane_nxt      = w_lane;
                        w_spawn_cnt_nxt = w_interval - 8'd1;
                    end else begin
                        w_spawn_cnt_nxt = r_spawn_cnt - 8'd1;
                    end
                    // A fatal hit still lets this frame's score and spawn updates land.
                    if ((r_state == S_PLAYING) && w_col_pend) begin
                        w_lives_nxt   = r_lives - 2'd1;
                        w_hit_cnt_nxt = '0;
                        w_state_nxt   = (r_lives == 2'd1) ? S_GAME_OVER : S_HIT;
                    end else if (r_state == S_HIT) begin
                        if (r_hit_cnt == HCW'(HIT_FRAMES - 1)) begin
                            w_hit_cnt_nxt = '0;
                            w_state_nxt   = S_PLAYING;
                        end else begin
                            w_hit_cnt_nxt = r_hit_cnt + HCW'(1);
                        end
                    end
                end
            end
            S_GAME_OVER: begin
                w_col_nxt = 1'b0;
                if (w_se) begin
                    w_state_nxt = S_IDLE;
                    w_score_clr = 1'b1;
                    w_speed_nxt = SPEED_W'(1);
                    w_lives_nxt = 2'(LIVES_INIT);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_100MHz or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_vsync_q    <= 1'b0;
            r_key_q      <= 1'b0;
            r_key_armed  <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_frame_cnt  <= '0;
            r_spawn_cnt  <= '0;
            r_hit_cnt    <= '0;
            r_col_latch  <= 1'b0;
            r_speed      <= SPEED_W'(1);
            r_lives      <= 2'(LIVES_INIT);
            r_frame_tick <= 1'b0;
            r_spawn      <= 1'b0;
            r_spawn_lane <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vsync_q    <= i_vsync;
            r_key_q      <= i_key_start;
            r_key_armed  <= r_key_armed | ~i_key_start;
            r_lfsr       <= lfsr_next(r_lfsr);
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_spawn_cnt  <= w_spawn_cnt_nxt;
            r_hit_cnt    <= w_hit_cnt_nxt;
            r_col_latch  <= w_col_nxt;
            r_speed      <= w_speed_nxt;
            r_lives      <= w_lives_nxt;
            r_frame_tick <= w_tick_nxt;
            r_spawn      <= w_spawn_nxt;
            r_spawn_lane <= w_lane_nxt;
        end
    end

    bcd_counter4 #(
        .LEVEL_POINTS (LEVEL_POINTS)
    ) u_bcd (
        .i_clk      (i_clk_100MHz),
        .i_rst_n    (i_reset),
        .i_inc      (w_score_inc),
        .i_clr      (w_score_clr),
        .o_score    (o_score),
        .o_level_up (w_level_up)
    );

    assign o_frame_tick = r_frame_tick;
    assign o_spawn      = r_spawn;
    assign o_spawn_lane = r_spawn_lane;
    assign o_speed      = r_speed;
    assign o_lives      = r_lives;
    assign o_game_state = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized frame/key/collision stimulus checked every cycle against a frame-count reference model.
module tb_game_sequencer;

    localparam int          LI   = 3;
    localparam int          HF   = 60;
    localparam int          SF   = 30;
    localparam int          LP   = 10;
    localparam int          SMAX = 7;
    localparam int          SB   = 64;
    localparam int          NL   = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        key_start;
    logic        collision;
    logic        frame_tick;
    logic        spawn;
    logic [2:0]  spawn_lane;
    logic [2:0]  speed;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [1:0]  game_state;

    game_sequencer #(
        .LIVES_INIT (LI), .HIT_FRAMES (HF), .SCORE_FRAMES (SF), .LEVEL_POINTS (LP),
        .SPEED_MAX (SMAX), .SPAWN_BASE (SB), .NUM_LANES (NL), .LFSR_SEED (SEED)
    ) dut (
        .i_clk_100MHz (clk),
        .i_reset      (rst_n),
        .i_vsync      (vsync),
        .i_key_start  (key_start),
        .i_collision  (collision),
        .o_frame_tick (frame_tick),
        .o_spawn      (spawn),
        .o_spawn_lane (spawn_lane),
        .o_speed      (speed),
        .o_lives      (lives),
        .o_score      (score),
        .o_game_state (game_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (game in frame numbers) ----------------
    int          m_state, m_score, m_lives, m_fnum, m_next_spawn, m_hit_n, e_lane;
    bit          m_col, m_vq, m_kq, m_armed, e_tick, e_spawn;
    logic [15:0] m_lfsr;

    function automatic int spd_of(input int sc);
        int s;
        s = 1 + sc / LP;
        return (s > SMAX) ? SMAX : s;
    endfunction

    function automatic int ivl(input int spd);
        int v;
        v = SB - 8 * spd;
        return (v < 8) ? 8 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = LI; m_fnum = 0; m_next_spawn = 0; m_hit_n = 0;
        m_col = 0; m_vq = 0; m_kq = 0; m_armed = 0; m_lfsr = SEED;
        e_tick = 0; e_spawn = 0; e_lane = 0;
    endtask

    task automatic model_step();
        bit fe, se, pend;
        int old_spd;
        fe = vsync && !m_vq;
        se = key_start && !m_kq && m_armed;
        e_tick = 0;
        e_spawn = 0;
        case (m_state)
            0: begin
                m_score = 0;
                m_lives = LI;
                if (se) begin
                    m_state = 1; m_fnum = 0; m_next_spawn = ivl(1) + 1;
                end
            end
            1, 2: begin
                pend = m_col || (collision && m_state == 1);
                if (fe) begin
                    old_spd = spd_of(m_score);
                    e_tick = 1;
                    m_fnum++;
                    if (m_fnum % SF == 0 && m_score < 9999) m_score++;
                    if (m_fnum == m_next_spawn) begin
                        e_spawn = 1;
                        e_lane = int'(m_lfsr[2:0]) % NL;
                        m_next_spawn += ivl(old_spd);
                    end
                    if (m_state == 1 && pend) begin
                        m_lives--;
                        m_state = (m_lives == 0) ? 3 : 2;
                        m_hit_n = 0;
                    end else if (m_state == 2) begin
                        m_hit_n++;
                        if (m_hit_n == HF) m_state = 1;
                    end
                    m_col = 0;
                end else begin
                    m_col = pend;
                end
            end
            default: begin
                if (se) begin
                    m_state = 0; m_score = 0; m_lives = LI;
                end
            end
        endcase
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_vq = vsync;
        m_kq = key_start;
        if (!key_start) m_armed = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle comparison and event counters ----------------
    bit chk_en = 0;
    int n_ticks = 0;
    int n_spawns = 0;
    int last_spawn_tick = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(game_state), 32'(m_state));
            chk("frame_tick", 32'(frame_tick), 32'(e_tick));
            chk("spawn", 32'(spawn), 32'(e_spawn));
            chk("spawn_lane", 32'(spawn_lane), 32'(e_lane));
            chk("speed", 32'(speed), 32'(spd_of(m_score)));
            chk("lives", 32'(lives), 32'(m_lives));
            chk("score", 32'(score), 32'(to_bcd(m_score)));
            if (frame_tick) n_ticks++;
            if (spawn) begin
                n_spawns++;
                last_spawn_tick = n_ticks;
                chk("lane_range", 32'(spawn_lane < 3'(NL)), 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic frame(input bit col, input bit key);
        vsync = 1'b1;
        if (key) key_start = 1'b1;
        @(negedge clk);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        vsync = 1'b0;
        if (key) key_start = 1'b0;
        collision = col;
        @(negedge clk);
        collision = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
    endtask

    task automatic frames(input int n, input int col_one_in);
        for (int i = 0; i < n; i++)
            frame((col_one_in > 0) && ($urandom_range(1, col_one_in) == 1), 1'b0);
    endtask

    task automatic press();
        key_start = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        key_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_spawn"}, 32'(spawn), 32'd0);
        chk({tag, "_lane"}, 32'(spawn_lane), 32'd0);
        chk({tag, "_speed"}, 32'(speed), 32'd1);
        chk({tag, "_lives"}, 32'(lives), 32'(LI));
        chk({tag, "_score"}, 32'(score), 32'h0);
        chk({tag, "_state"}, 32'(game_state), 32'd0);
    endtask

    int t0, s0;

    initial begin
        rst_n = 1'b0; vsync = 1'b0; key_start = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk_reset_values("reset");

        // No key: stay idle, no ticks.
        t0 = n_ticks;
        frames(3, 0);
        chk("idle_ticks", 32'(n_ticks - t0), 32'd0);
        chk("idle_state", 32'(game_state), 32'd0);

        // Start and play 90 clean frames.
        press();
        chk("start_state", 32'(game_state), 32'd1);
        t0 = n_ticks; s0 = n_spawns;
        frames(90, 0);
        chk("play_ticks", 32'(n_ticks - t0), 32'd90);
        chk("play_score", 32'(score), 32'h0003);
        chk("first_spawn_cnt", 32'(n_spawns - s0), 32'd1);
        chk("first_spawn_frame", 32'(last_spawn_tick - t0), 32'd57);

        // Single hit, immunity window, resume.
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        chk("hit1_lives", 32'(lives), 32'd2);
        chk("hit1_state", 32'(game_state), 32'd2);
        frames(HF - 1, 3);
        chk("hit1_hold", 32'(game_state), 32'd2);
        chk("hit1_immune", 32'(lives), 32'd2);
        frame(1'b0, 1'b0);
        chk("hit1_resume", 32'(game_state), 32'd1);

        // Second and third hit end the game.
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        chk("hit2_lives", 32'(lives), 32'd1);
        frames(HF, 0);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        chk("over_state", 32'(game_state), 32'd3);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_score", 32'(score), 32'h0007);
        t0 = n_ticks;
        frames(5, 2);
        chk("over_ticks", 32'(n_ticks - t0), 32'd0);
        chk("over_frozen", 32'(score), 32'h0007);
        press();
        chk("back_idle", 32'(game_state), 32'd0);
        chk("idle_score", 32'(score), 32'h0);
        chk("idle_lives", 32'(lives), 32'(LI));

        // Start key coincident with the frame edge: start, but no tick for that frame.
        t0 = n_ticks;
        frame(1'b0, 1'b1);
        chk("same_cycle_state", 32'(game_state), 32'd1);
        chk("same_cycle_ticks", 32'(n_ticks - t0), 32'd0);

        // Level-up boundary and speed saturation.
        frames(299, 0);
        chk("score_9", 32'(score), 32'h0009);
        chk("speed_1", 32'(speed), 32'd1);
        frame(1'b0, 1'b0);
        chk("score_10", 32'(score), 32'h0010);
        chk("speed_2", 32'(speed), 32'd2);
        frames(1800, 0);
        chk("score_70", 32'(score), 32'h0070);
        chk("speed_sat", 32'(speed), 32'(SMAX));

        // Reset in the middle of HIT with hit_cnt at 30, key held across release.
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        chk("pre_rst_state", 32'(game_state), 32'd2);
        frames(30, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        key_start = 1'b1;
        #1;
        chk_reset_values("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames(3, 0);
        chk("held_key_no_start", 32'(game_state), 32'd0);
        key_start = 1'b0;
        @(negedge clk);
        press();
        chk("restart_state", 32'(game_state), 32'd1);

        // Random play with frequent collisions and stray key presses.
        for (int i = 0; i < 300; i++) begin
            if (m_state == 3) begin
                press();
                press();
            end
            frame($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
